// File: rtl/ws2812_driver_if.sv
// Engine-to-driver bundle for ws2812_driver: the frame word plus the Start/Busy/Done handshake and the serial line.
interface ws2812_driver_if #(
    parameter int NUM_LEDS = 5
);
    logic [24*NUM_LEDS-1:0] GRBSeq;
    logic                   Start;
    logic                   Dout;
    logic                   Busy;
    logic                   Done;

    modport master (output GRBSeq, output Start, input Dout, input Busy, input Done);
    modport slave  (input GRBSeq, input Start, output Dout, output Busy, output Done);
endinterface

// File: rtl/ws2812_driver.sv
// WS2812 serialiser: shifts a NUM_LEDS x 24-bit GRB frame out MSB first, then holds the line low for the latch time.
// Optional `WS2812_PENDING_EN builds a one-deep request queue so a frame requested while busy follows without an idle gap.
module ws2812_driver #(
    parameter int NUM_LEDS = 5,
    parameter int T0H      = 35,
    parameter int T1H      = 70,
    parameter int TBIT     = 125,
    parameter int TRESET   = 6000
) (
    input  logic           clk,
    input  logic           reset,
    ws2812_driver_if.slave bus
);
    localparam int FW   = 24 * NUM_LEDS;
    localparam int BW   = $clog2(FW);
    localparam int TMAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int TW   = $clog2(TMAX);

    localparam logic [BW-1:0] C_LAST      = BW'(FW - 1);
    localparam logic [TW-1:0] C_TBIT_M1   = TW'(TBIT - 1);
    localparam logic [TW-1:0] C_TRESET_M1 = TW'(TRESET - 1);
    localparam logic [TW-1:0] C_T0H       = TW'(T0H);
    localparam logic [TW-1:0] C_T1H       = TW'(T1H);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t          r_state, w_state;
    logic [FW-1:0]   r_shift, w_shift;
    logic [BW-1:0]   r_bitcnt, w_bitcnt;
    logic [TW-1:0]   r_timer, w_timer;
    logic            r_dout, w_dout;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic [TW-1:0]   w_thigh;
`ifdef WS2812_PENDING_EN
    logic            r_pend, w_pend;
    logic [FW-1:0]   r_hold, w_hold;
`endif

    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_bitcnt = r_bitcnt;
        w_timer  = r_timer;
        w_dout   = 1'b0;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_thigh  = r_shift[FW-1] ? C_T1H : C_T0H;
`ifdef WS2812_PENDING_EN
        w_pend   = r_pend;
        w_hold   = r_hold;
        // A request in the final latch cycle lands here too and is consumed on the same edge below.
        if (r_state != IDLE && bus.Start) begin
            w_pend = 1'b1;
            w_hold = bus.GRBSeq;
        end
`endif
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.Start) begin
                    w_shift  = bus.GRBSeq;
                    w_bitcnt = '0;
                    w_timer  = '0;
                    w_dout   = 1'b1;
                    w_busy   = 1'b1;
                    w_state  = SEND;
                end
            end
            SEND: begin
                if (r_timer == C_TBIT_M1) begin
                    w_shift = r_shift << 1;
                    w_timer = '0;
                    if (r_bitcnt == C_LAST) begin
                        w_bitcnt = '0;
                        w_state  = LATCH;
                    end else begin
                        w_bitcnt = r_bitcnt + BW'(1);
                        w_dout   = 1'b1;
                    end
                end else begin
                    // Dout is registered, so compare against the timer value it will be shown with.
                    w_timer = r_timer + TW'(1);
                    w_dout  = (w_timer < w_thigh);
                end
            end
            LATCH: begin
                if (r_timer == C_TRESET_M1) begin
                    w_timer = '0;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
`ifdef WS2812_PENDING_EN
                    if (w_pend) begin
                        w_shift  = w_hold;
                        w_bitcnt = '0;
                        w_dout   = 1'b1;
                        w_busy   = 1'b1;
                        w_pend   = 1'b0;
                        w_state  = SEND;
                    end
`endif
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            default: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_timer  <= '0;
            r_dout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef WS2812_PENDING_EN
            r_pend   <= 1'b0;
            r_hold   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_bitcnt <= w_bitcnt;
            r_timer  <= w_timer;
            r_dout   <= w_dout;
            r_busy   <= w_busy;
            r_done   <= w_done;
`ifdef WS2812_PENDING_EN
            r_pend   <= w_pend;
            r_hold   <= w_hold;
`endif
        end
    end

    assign bus.Dout = r_dout;
    assign bus.Busy = r_busy;
    assign bus.Done = r_done;
endmodule

// File: tb/tb_ws2812_driver.sv
// Directed bench for ws2812_driver: decodes Dout pulse widths back into frames and checks timing against hand-derived values.
`timescale 1ns/1ps
module tb_ws2812_driver;
    localparam int NL       = 5;
    localparam int P_T0H    = 3;
    localparam int P_T1H    = 6;
    localparam int P_TBIT   = 10;
    localparam int P_TRESET = 40;
    localparam int FW       = 24 * NL;
    localparam int FLEN     = FW * P_TBIT + P_TRESET;
`ifdef WS2812_PENDING_EN
    localparam int GAP_EXTRA = 0;
`else
    localparam int GAP_EXTRA = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    ws2812_driver_if #(.NUM_LEDS(NL)) bus ();

    ws2812_driver #(
        .NUM_LEDS(NL),
        .T0H     (P_T0H),
        .T1H     (P_T1H),
        .TBIT    (P_TBIT),
        .TRESET  (P_TRESET)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   hl_q[$];
    int   rise_q[$];
    int   fall_q[$];
    int   done_q[$];
    int   busy_cnt = 0;
    int   hrun = 0;
    logic prev_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Dout && !prev_d) begin
            rise_q.push_back(cyc);
            hrun = 0;
        end
        if (bus.Dout) hrun++;
        if (!bus.Dout && prev_d) begin
            hl_q.push_back(hrun);
            fall_q.push_back(cyc);
        end
        if (bus.Done) done_q.push_back(cyc);
        if (bus.Busy) busy_cnt++;
        prev_d = bus.Dout;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hl_q.delete();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, done_q.size(), n);
    endtask

    task automatic wait_rises(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rise_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, rise_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (bus.Busy && k < budget) begin
            tick();
            k++;
        end
        chk(tag, bus.Busy, 0);
    endtask

    // Rebuilds the frame starting at pulse index off and checks it against exp and the done with index di.
    task automatic check_frame(input int off, input int di, input logic [FW-1:0] exp, input string tag);
        logic [FW-1:0] got;
        int bad;
        int len;
        int th_last;
        logic ok;
        got = '0;
        bad = 0;
        ok = (hl_q.size() >= off + FW) && (done_q.size() > di);
        chk({tag, "_avail"}, ok, 1);
        if (!ok) return;
        for (int i = 0; i < FW; i++) begin
            len = hl_q[off+i];
            if (len != P_T0H && len != P_T1H) bad++;
            got[FW-1-i] = (len == P_T1H);
            if (i > 0 && rise_q[off+i] - rise_q[off+i-1] != P_TBIT) bad++;
        end
        th_last = exp[0] ? P_T1H : P_T0H;
        chk({tag, "_frame"}, got, exp);
        chk({tag, "_badbits"}, bad, 0);
        chk({tag, "_len"}, done_q[di] - rise_q[off], FLEN);
        chk({tag, "_latch"}, done_q[di] - fall_q[off+FW-1], P_TBIT - th_last + P_TRESET);
    endtask

    logic [FW-1:0] f2, f3, fa, fb, fc;

    initial begin
        f2 = {24'h00FF00, 96'h0};
        f3 = 120'h123456_89ABCD_FEDCBA_000001_800000;
        fa = 120'hA5A5A5_0F0F0F_FFFFFF_000000_C3C3C3;
        fb = 120'h5A5A5A_F0F0F0_123456_ABCDEF_010203;
        fc = 120'hFFFFFF_FFFFFF_FFFFFF_FFFFFF_FFFFFF;
        bus.GRBSeq = '0;
        bus.Start  = 1'b0;
        reset      = 1'b1;
        repeat (3) tick();
        chk("rst_dout", bus.Dout, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        reset = 1'b0;
        tick();

        // All-zero frame
        clear_mon();
        bus.GRBSeq = '0;
        pulse_start();
        chk("lat_dout", bus.Dout, 1);
        chk("lat_busy", bus.Busy, 1);
        wait_dones(1, FLEN + 20, "t1_done");
        check_frame(0, 0, '0, "t1");
        repeat (3) tick();
        chk("t1_busycyc", busy_cnt, FLEN);
        chk("t1_idle", bus.Busy, 0);
        chk("t1_ndone", done_q.size(), 1);
        chk("t1_npulse", hl_q.size(), FW);

        // LED0 red channel only, frame word changed mid-flight
        clear_mon();
        bus.GRBSeq = f2;
        pulse_start();
        wait_rises(20, FLEN, "t2_rise");
        bus.GRBSeq = fc;
        wait_dones(1, FLEN + 20, "t2_done");
        check_frame(0, 0, f2, "t2");
        repeat (3) tick();

        // Start held high: the request is seen in the Done cycle (or queued when pending is built)
        clear_mon();
        bus.GRBSeq = f3;
        bus.Start  = 1'b1;
        wait_dones(3, 3 * FLEN + 50, "t3_done");
        bus.Start  = 1'b0;
        bus.GRBSeq = '0;
        wait_idle(3 * FLEN, "t3_drain");
        chk("t3_gap1", done_q[1] - done_q[0], FLEN + GAP_EXTRA);
        chk("t3_gap2", done_q[2] - done_q[1], FLEN + GAP_EXTRA);
        chk("t3_restart", rise_q[FW] - done_q[0], GAP_EXTRA);
        chk("t3_lowgap", rise_q[FW] - fall_q[FW-1], P_TBIT - P_T0H + P_TRESET + GAP_EXTRA);
        check_frame(0, 0, f3, "t3a");
        check_frame(FW, 1, f3, "t3b");
        repeat (3) tick();

        // Second request around bit 50
        clear_mon();
        bus.GRBSeq = fa;
        pulse_start();
        wait_rises(51, FLEN, "t4_rise");
        bus.GRBSeq = fb;
        pulse_start();
        bus.GRBSeq = fc;
`ifdef WS2812_PENDING_EN
        wait_dones(2, 2 * FLEN + 50, "t4_done");
        check_frame(0, 0, fa, "t4a");
        check_frame(FW, 1, fb, "t4b");
        chk("t4_chain", rise_q[FW], done_q[0]);
        repeat (3) tick();
        chk("t4_busycyc", busy_cnt, 2 * FLEN);
        chk("t4_idle", bus.Busy, 0);
`else
        wait_dones(1, FLEN + 20, "t4_done");
        check_frame(0, 0, fa, "t4a");
        repeat (2 * FLEN) tick();
        chk("t4_ndone", done_q.size(), 1);
        chk("t4_npulse", rise_q.size(), FW);
        chk("t4_idle", bus.Busy, 0);
`endif

        // Reset while bit 30 is high
        clear_mon();
        bus.GRBSeq = fa;
        pulse_start();
        wait_rises(31, FLEN, "t5_rise");
        chk("t5_pre", bus.Dout, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_dout", bus.Dout, 0);
        chk("t5_busy", bus.Busy, 0);
        chk("t5_done", bus.Done, 0);
        repeat (FLEN + 20) tick();
        chk("t5_nodone", done_q.size(), 0);
        clear_mon();
        bus.GRBSeq = fb;
        pulse_start();
        wait_dones(1, FLEN + 20, "t5b_done");
        check_frame(0, 0, fb, "t5b");
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
